// File: rtl/timx_apb_cfg_seq_if.sv
// APB write bus between the config sequencer and the timer slave port.
// Only the write subset is carried.
interface timx_apb_cfg_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr
  );
endinterface

// File: rtl/timx_apb_cfg_seq.sv
// APB master replaying an (address, data) table into the timer.
// Reports completion, slave error and access timeout.
module timx_apb_cfg_seq #(
  parameter int MAX_ENTRIES = 16,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int GAP_CYCLES  = 0,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = $clog2(MAX_ENTRIES)
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              tbl_last,
  timx_apb_cfg_seq_if.master timx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              err_q;
  logic [IDX_W-1:0]  err_idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (timx.pready) begin
          cnt_d = '0;
          if (timx.pslverr) begin
            state_d = S_ERR;
          end else if (last_q || idx_q == IDX_MAX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (state_q == S_FETCH) begin
        paddr_q  <= tbl_addr;
        pwdata_q <= tbl_data;
        last_q   <= tbl_last;
      end
      if (state_q == S_IDLE && start) err_q <= 1'b0;
      if (state_q == S_ERR) begin
        err_q     <= 1'b1;
        err_idx_q <= idx_q;
      end
    end
  end

  assign timx.psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign timx.penable = (state_q == S_ACCESS);
  assign timx.pwrite  = timx.psel;
  assign timx.paddr   = paddr_q;
  assign timx.pwdata  = pwdata_q;

  assign tbl_idx = idx_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_timx_apb_cfg_seq.sv
// Directed bench for timx_apb_cfg_seq: replay, gaps, slave error,
// timeout, reset mid-transfer and forced last entry.
module tb_timx_apb_cfg_seq;

  logic apb_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 apb_clk = ~apb_clk;

  int cyc = 0;
  always @(posedge apb_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic logic [47:0] ent(int i);
    case (i)
      0:       return {16'h002C, 32'h0000_0008};
      1:       return {16'h0034, 32'h0000_0002};
      2:       return {16'h0018, 32'h0000_0038};
      3:       return {16'h0020, 32'h0000_0005};
      4:       return {16'h0044, 32'h0000_8000};
      5:       return {16'h0014, 32'h0000_0001};
      6:       return {16'h0000, 32'h0000_0001};
      default: return {16'h00F0, 32'h0000_DEAD};
    endcase
  endfunction

  // instance a: default gap, TIMEOUT=8
  logic a_start = 0, a_rdy = 1, a_inj = 0;
  logic [3:0] a_idx, a_eidx;
  logic [15:0] a_addr;
  logic [31:0] a_data;
  logic a_busy, a_done, a_err;
  timx_apb_cfg_seq_if #(.ADDR_W(16), .DATA_W(32)) ia ();
  assign {a_addr, a_data} = ent(int'(a_idx));
  assign ia.pready  = a_rdy;
  assign ia.pslverr = a_inj && (a_idx == 4'd3);

  timx_apb_cfg_seq #(.MAX_ENTRIES(16), .GAP_CYCLES(0), .TIMEOUT(8)) u_a (
    .apb_clk(apb_clk), .apb_rst_n(rst_n), .start(a_start),
    .tbl_idx(a_idx), .tbl_addr(a_addr), .tbl_data(a_data),
    .tbl_last(a_idx == 4'd6), .timx(ia),
    .busy(a_busy), .done(a_done), .err(a_err), .err_idx(a_eidx));

  // instance b: GAP_CYCLES=4
  logic b_start = 0;
  logic [3:0] b_idx, b_eidx;
  logic [15:0] b_addr;
  logic [31:0] b_data;
  logic b_busy, b_done, b_err;
  timx_apb_cfg_seq_if #(.ADDR_W(16), .DATA_W(32)) ib ();
  assign {b_addr, b_data} = ent(int'(b_idx));
  assign ib.pready  = 1'b1;
  assign ib.pslverr = 1'b0;

  timx_apb_cfg_seq #(.MAX_ENTRIES(16), .GAP_CYCLES(4)) u_b (
    .apb_clk(apb_clk), .apb_rst_n(rst_n), .start(b_start),
    .tbl_idx(b_idx), .tbl_addr(b_addr), .tbl_data(b_data),
    .tbl_last(b_idx == 4'd6), .timx(ib),
    .busy(b_busy), .done(b_done), .err(b_err), .err_idx(b_eidx));

  // instance c: MAX_ENTRIES=4, tbl_last never set
  logic c_start = 0;
  logic [1:0] c_idx, c_eidx;
  logic [15:0] c_addr;
  logic [31:0] c_data;
  logic c_busy, c_done, c_err;
  timx_apb_cfg_seq_if #(.ADDR_W(16), .DATA_W(32)) ic ();
  assign {c_addr, c_data} = ent(int'(c_idx));
  assign ic.pready  = 1'b1;
  assign ic.pslverr = 1'b0;

  timx_apb_cfg_seq #(.MAX_ENTRIES(4)) u_c (
    .apb_clk(apb_clk), .apb_rst_n(rst_n), .start(c_start),
    .tbl_idx(c_idx), .tbl_addr(c_addr), .tbl_data(c_data),
    .tbl_last(1'b0), .timx(ic),
    .busy(c_busy), .done(c_done), .err(c_err), .err_idx(c_eidx));

  // bus monitors, each the only writer of its variables
  logic [47:0] a_log[$];
  logic [31:0] cr1 = '0;
  logic [47:0] a_hold = '0;
  int a_dones = 0, bad_pw = 0, bad_stab = 0, c_wr = 0;

  always @(posedge apb_clk) begin
    if (rst_n) begin
      if (ia.psel && ia.penable && ia.pready && !ia.pslverr) begin
        a_log.push_back({ia.paddr, ia.pwdata});
        if (ia.paddr == 16'h0000) cr1 = ia.pwdata;
      end
      if (ia.psel && !ia.pwrite) bad_pw++;
      if (ib.psel && !ib.pwrite) bad_pw++;
      if (ia.psel && !ia.penable) a_hold = {ia.paddr, ia.pwdata};
      if (ia.psel && ia.penable && a_hold != {ia.paddr, ia.pwdata})
        bad_stab++;
      if (a_done) a_dones++;
      if (ic.psel && ic.penable && ic.pready) c_wr++;
    end
  end

  // psel-low run length between consecutive writes on instance b
  int b_run = 0, b_min = 999, b_max = 0, b_wr = 0;
  bit b_seen = 0;
  always @(negedge apb_clk) begin
    if (!b_busy) begin
      b_run  = 0;
      b_seen = 0;
    end else if (ib.psel) begin
      if (b_seen && b_run > 0) begin
        if (b_run < b_min) b_min = b_run;
        if (b_run > b_max) b_max = b_run;
      end
      if (ib.penable) b_wr++;
      b_run  = 0;
      b_seen = 1;
    end else if (b_seen) begin
      b_run++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic done_of(int s);
    case (s)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  // start pulse sampled at the next posedge; s is the cycle-0 reference
  task automatic pulse(input int sel, output int s);
    @(negedge apb_clk);
    case (sel)
      0:       a_start = 1;
      1:       b_start = 1;
      default: c_start = 1;
    endcase
    s = cyc;
    @(negedge apb_clk);
    a_start = 0;
    b_start = 0;
    c_start = 0;
  endtask

  task automatic wait_done(input int sel, input int s, output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge apb_clk);
      if (done_of(sel)) begin
        c = cyc - s;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge apb_clk);
      if (!a_busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  int s, c, base, ok, en, dn;

  initial begin
    repeat (2) @(negedge apb_clk);
    chk("rst_ctl", {ia.psel, ia.penable, ia.pwrite, a_busy, a_done, a_err}, 0);
    chk("rst_bus", {ia.paddr, ia.pwdata}, 0);
    chk("rst_idx", {a_idx, a_eidx}, 0);

    // start coincident with reset: reset wins
    a_start = 1;
    @(negedge apb_clk);
    a_start = 0;
    chk("rst_vs_start", a_busy, 0);
    rst_n = 1;
    @(negedge apb_clk);
    chk("still_idle", a_busy, 0);

    // 1: seven-entry replay
    base = a_log.size();
    pulse(0, s);
    wait_done(0, s, c);
    chk("t1_done_cyc", c, 22);
    chk("t1_nwr", a_log.size() - base, 7);
    if (a_log.size() >= base + 7)
      for (int i = 0; i < 7; i++)
        chk($sformatf("t1_wr%0d", i), a_log[base+i], ent(i));
    chk("t1_cr1", cr1, 1);
    @(negedge apb_clk);
    chk("t1_idle", {a_busy, a_done, a_err}, 0);

    // 2: GAP_CYCLES=4 adds four idle cycles per non-final entry
    pulse(1, s);
    wait_done(1, s, c);
    chk("t2_done_cyc", c, 46);
    chk("t2_nwr", b_wr, 7);
    chk("t2_run_min", b_min, 5);
    chk("t2_run_max", b_max, 5);

    // 3: slave error on entry 3
    a_inj = 1;
    base = a_log.size();
    dn = a_dones;
    pulse(0, s);
    wait_idle(ok);
    chk("t3_idle", ok, 1);
    chk("t3_nwr", a_log.size() - base, 3);
    chk("t3_err", a_err, 1);
    chk("t3_err_idx", a_eidx, 3);
    chk("t3_no_done", a_dones - dn, 0);
    a_inj = 0;
    base = a_log.size();
    pulse(0, s);
    chk("t3_err_clr", a_err, 0);
    chk("t3_restart_idx", a_idx, 0);
    wait_done(0, s, c);
    chk("t3_re_done", c, 22);
    chk("t3_re_nwr", a_log.size() - base, 7);
    if (a_log.size() > base) chk("t3_re_first", a_log[base], ent(0));

    // 4: pready held low, TIMEOUT=8
    a_rdy = 0;
    en = 0;
    pulse(0, s);
    for (int k = 2; k <= 12; k++) begin
      @(negedge apb_clk);
      if (ia.penable) en++;
      if (k == 11) chk("t4_psel_drop", ia.psel, 0);
      if (k == 12) begin
        chk("t4_err", a_err, 1);
        chk("t4_err_idx", a_eidx, 0);
        chk("t4_busy", a_busy, 0);
      end
    end
    chk("t4_access_len", en, 8);
    a_rdy = 1;

    // 5: repeated start ignored, reset during ACCESS of entry 2
    base = a_log.size();
    pulse(0, s);
    @(negedge apb_clk);
    a_start = 1;
    @(negedge apb_clk);
    a_start = 0;
    c = -1;
    for (int k = 0; k < 30; k++) begin
      if (a_idx == 4'd2 && ia.penable) begin
        c = cyc - s;
        break;
      end
      @(negedge apb_clk);
    end
    chk("t5_e2_access_cyc", c, 9);
    rst_n = 0;
    @(negedge apb_clk);
    chk("t5_rst_ctl", {ia.psel, ia.penable, ia.pwrite, a_busy, a_done, a_err}, 0);
    chk("t5_rst_bus", {ia.paddr, ia.pwdata, a_idx, a_eidx}, 0);
    chk("t5_nwr", a_log.size() - base, 2);
    if (a_log.size() >= base + 2) chk("t5_wr1", a_log[base+1], ent(1));
    rst_n = 1;
    base = a_log.size();
    pulse(0, s);
    wait_done(0, s, c);
    chk("t5_re_done", c, 22);
    chk("t5_re_nwr", a_log.size() - base, 7);
    if (a_log.size() > base) chk("t5_re_first", a_log[base], ent(0));

    // 6: no tbl_last, MAX_ENTRIES=4
    pulse(2, s);
    wait_done(2, s, c);
    chk("t6_done_cyc", c, 13);
    chk("t6_nwr", c_wr, 4);

    chk("pwrite_hi", bad_pw, 0);
    chk("bus_stable", bad_stab, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
